qr_pattern_writer: RTL and testbench

Writes the function patterns of a 21×21 QR symbol (three 7×7 finders, two timing lines) into the 64×64 one-bit image SRAM at a given location and orientation. It is the write-side counterpart of the corner/rotation detector: the orientation code it takes is the same empty-corner code the detector produces. It is used for self-test image generation and for regenerating symbols in the QR pipeline. It issues one SRAM write per cycle under a start/busy/done handshake.

---
 rtl/qr_pkg.sv | 59 +++++
 rtl/qr_coord_xform.sv | 64 ++++++
 rtl/qr_pattern_writer.sv | 253 +++++++++++++++++++++++++
 tb/tb_qr_pattern_writer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// ---------------------------------------------------------------------------
// qr_pkg
//
// Shared definitions for the QR function-pattern blocks (this writer and the
// corner/rotation detector). Holds:
//   - the writer FSM state encoding
//   - 21x21 symbol geometry (finder size/placement, timing-line placement)
//   - the number of writes a full pattern job issues
//   - the empty-corner rotation codes
//   - finder_bit(): the dark/light value of a finder module from its offset
// ---------------------------------------------------------------------------
package qr_pkg;

    // Image / address geometry defaults
    localparam int IMG_W_DEF = 64;
    localparam int AW_DEF    = 12;

    // Symbol geometry in canonical coordinates (empty corner at bottom-right)
    localparam int SYM_SIZE   = 21;
    localparam int FINDER_SZ  = 7;
    localparam int FINDER_FAR = 14;   // origin offset of the far finders
    localparam int N_FINDERS  = 3;
    localparam int TIM_LO     = 8;    // first index of each timing line
    localparam int TIM_LEN    = 5;    // modules per timing line
    localparam int TIM_IDX    = 6;    // fixed row (TIMH) / column (TIMV)

    localparam int N_WRITES = N_FINDERS * FINDER_SZ * FINDER_SZ + 2 * TIM_LEN;

    // Largest top-left coordinate that keeps the whole symbol in the image
    localparam int LOC_MAX = IMG_W_DEF - SYM_SIZE;

    // Empty-corner codes, identical to the detector's output encoding
    localparam logic [1:0] ROT_TL = 2'd0;
    localparam logic [1:0] ROT_TR = 2'd1;
    localparam logic [1:0] ROT_BL = 2'd2;
    localparam logic [1:0] ROT_BR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FIND = 3'd1,
        ST_TIMH = 3'd2,
        ST_TIMV = 3'd3,
        ST_DONE = 3'd4
    } qr_state_e;

    // Finder module value: the ring at Chebyshev distance 2 from the finder
    // centre (3,3) is light; everything else in the 7x7 block is dark.
    function automatic logic finder_bit(input logic [2:0] dr, input logic [2:0] dc);
        logic [2:0] ar;
        logic [2:0] ac;
        logic       on_ring;
        ar = (dr >= 3'd3) ? (dr - 3'd3) : (3'd3 - dr);
        ac = (dc >= 3'd3) ? (dc - 3'd3) : (3'd3 - dc);
        // max(ar,ac) == 2  <=>  both <= 2 and at least one == 2
        on_ring = (ar <= 3'd2) && (ac <= 3'd2) && ((ar == 3'd2) || (ac == 3'd2));
        return !on_ring;
    endfunction

endpackage

// File: rtl/qr_coord_xform.sv
// ---------------------------------------------------------------------------
// qr_coord_xform
//
// Combinational canonical-to-physical address mapping. The pattern is
// generated with the empty corner at bottom-right; this block rotates the
// canonical (r,c) into the requested orientation and offsets it by the
// symbol location.
//
// Ports:
//   r, c           in  5   canonical row/column, 0..20
//   rotation_type  in  2   empty corner code (ROT_TL/TR/BL/BR)
//   loc_y, loc_x   in  6   symbol top-left row/column in the image
//   addr           out AW  (loc_y+pr)*IMG_W + (loc_x+pc)
// ---------------------------------------------------------------------------
module qr_coord_xform
    import qr_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic [4:0]    r,
    input  logic [4:0]    c,
    input  logic [1:0]    rotation_type,
    input  logic [5:0]    loc_y,
    input  logic [5:0]    loc_x,
    output logic [AW-1:0] addr
);

    localparam logic [4:0] EDGE = 5'(SYM_SIZE - 1);

    logic [4:0]    pr;
    logic [4:0]    pc;
    logic [AW-1:0] row;
    logic [AW-1:0] col;

    always_comb begin
        pr = r;
        pc = c;
        case (rotation_type)
            ROT_BR: begin
                pr = r;
                pc = c;
            end
            ROT_BL: begin
                pr = c;
                pc = EDGE - r;
            end
            ROT_TR: begin
                pr = EDGE - c;
                pc = r;
            end
            default: begin  // ROT_TL
                pr = EDGE - r;
                pc = EDGE - c;
            end
        endcase

        // Full-width sums: location is range-checked upstream so no wrap.
        row  = AW'(loc_y) + AW'(pr);
        col  = AW'(loc_x) + AW'(pc);
        addr = row * AW'(IMG_W) + col;
    end

endmodule

// File: rtl/qr_pattern_writer.sv
// ---------------------------------------------------------------------------
// qr_pattern_writer
//
// Writes the function patterns of a 21x21 QR symbol (three finders, two
// timing lines) into a 64x64 one-bit image SRAM, one write per cycle.
// Job order: finders at canonical (0,0), (0,14), (14,0), each row-major;
// then the horizontal timing line (row 6, c=8..12); then the vertical one
// (column 6, r=8..12). 157 writes in total.
//
// Ports:
//   clk            in  1   clock, rising edge
//   rst            in  1   asynchronous active-high reset
//   start          in  1   job request, sampled only in IDLE
//   loc_y, loc_x   in  6   symbol top-left, latched at start
//   rotation_type  in  2   empty-corner code, latched at start
//   busy           out 1   job in progress
//   done           out 1   one-cycle completion pulse
//   loc_err        out 1   pulses with done when the location was illegal
//   sram_wen       out 1   write strobe
//   sram_waddr     out AW  write address (holds when sram_wen=0)
//   sram_wdata     out 1   write data, 1 = dark (holds when sram_wen=0)
//
// Handshake: start is accepted only in IDLE. From the accepting edge, busy
// stays high until the done pulse; done pulses for one cycle and the block is
// back in IDLE in that same cycle, so a held start relaunches immediately.
// ---------------------------------------------------------------------------
module qr_pattern_writer
    import qr_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [5:0]    loc_y,
    input  logic [5:0]    loc_x,
    input  logic [1:0]    rotation_type,
    output logic          busy,
    output logic          done,
    output logic          loc_err,
    output logic          sram_wen,
    output logic [AW-1:0] sram_waddr,
    output logic          sram_wdata
);

    localparam logic [2:0] FIND_LAST = 3'(FINDER_SZ - 1);
    localparam logic [1:0] FIDX_LAST = 2'(N_FINDERS - 1);
    localparam logic [2:0] TIM_LAST  = 3'(TIM_LEN - 1);

    // FSM and counters
    qr_state_e     state_q, state_d;
    logic [1:0]    fidx_q, fidx_d;     // finder index 0..2
    logic [2:0]    dr_q, dr_d;         // finder row offset
    logic [2:0]    dc_q, dc_d;         // finder column offset
    logic [2:0]    tcnt_q, tcnt_d;     // timing-line position 0..4

    // Job parameters latched at start
    logic [5:0]    loc_y_q, loc_y_d;
    logic [5:0]    loc_x_q, loc_x_d;
    logic [1:0]    rot_q, rot_d;
    logic          err_q, err_d;

    // Registered outputs
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          loc_err_q, loc_err_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          wdata_q, wdata_d;

    // Current write in canonical coordinates
    logic [4:0]    can_r;
    logic [4:0]    can_c;
    logic          can_bit;
    logic [AW-1:0] xf_addr;
    logic          loc_ok;

    assign loc_ok = (loc_y <= 6'(LOC_MAX)) && (loc_x <= 6'(LOC_MAX));

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        fidx_d  = fidx_q;
        dr_d    = dr_q;
        dc_d    = dc_q;
        tcnt_d  = tcnt_q;
        loc_y_d = loc_y_q;
        loc_x_d = loc_x_q;
        rot_d   = rot_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    loc_y_d = loc_y;
                    loc_x_d = loc_x;
                    rot_d   = rotation_type;
                    err_d   = !loc_ok;
                    fidx_d  = 2'd0;
                    dr_d    = 3'd0;
                    dc_d    = 3'd0;
                    tcnt_d  = 3'd0;
                    state_d = loc_ok ? ST_FIND : ST_DONE;
                end
            end
            ST_FIND: begin
                if (dc_q == FIND_LAST) begin
                    dc_d = 3'd0;
                    if (dr_q == FIND_LAST) begin
                        dr_d = 3'd0;
                        if (fidx_q == FIDX_LAST) begin
                            fidx_d  = 2'd0;
                            state_d = ST_TIMH;
                        end else begin
                            fidx_d = fidx_q + 2'd1;
                        end
                    end else begin
                        dr_d = dr_q + 3'd1;
                    end
                end else begin
                    dc_d = dc_q + 3'd1;
                end
            end
            ST_TIMH: begin
                if (tcnt_q == TIM_LAST) begin
                    tcnt_d  = 3'd0;
                    state_d = ST_TIMV;
                end else begin
                    tcnt_d = tcnt_q + 3'd1;
                end
            end
            ST_TIMV: begin
                if (tcnt_q == TIM_LAST) begin
                    tcnt_d  = 3'd0;
                    state_d = ST_DONE;
                end else begin
                    tcnt_d = tcnt_q + 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Canonical coordinate and data for the write issued this cycle
    // ------------------------------------------------------------------
    always_comb begin
        can_r   = 5'd0;
        can_c   = 5'd0;
        can_bit = 1'b0;
        case (state_q)
            ST_FIND: begin
                // Finder 1 sits at the far column, finder 2 at the far row.
                can_r   = ((fidx_q == 2'd2) ? 5'(FINDER_FAR) : 5'd0) + 5'(dr_q);
                can_c   = ((fidx_q == 2'd1) ? 5'(FINDER_FAR) : 5'd0) + 5'(dc_q);
                can_bit = finder_bit(dr_q, dc_q);
            end
            ST_TIMH: begin
                can_r   = 5'(TIM_IDX);
                can_c   = 5'(TIM_LO) + 5'(tcnt_q);
                can_bit = ~can_c[0];   // dark on even index
            end
            ST_TIMV: begin
                can_r   = 5'(TIM_LO) + 5'(tcnt_q);
                can_c   = 5'(TIM_IDX);
                can_bit = ~can_r[0];
            end
            default: begin
                can_r   = 5'd0;
                can_c   = 5'd0;
                can_bit = 1'b0;
            end
        endcase
    end

    qr_coord_xform #(
        .IMG_W (IMG_W),
        .AW    (AW)
    ) u_xform (
        .r             (can_r),
        .c             (can_c),
        .rotation_type (rot_q),
        .loc_y         (loc_y_q),
        .loc_x         (loc_x_q),
        .addr          (xf_addr)
    );

    // ------------------------------------------------------------------
    // Output register inputs
    // ------------------------------------------------------------------
    always_comb begin
        // busy covers every cycle the FSM is out of IDLE, including DONE,
        // so it drops exactly when done rises.
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_q == ST_DONE);
        loc_err_d = (state_q == ST_DONE) && err_q;
        wen_d     = (state_q == ST_FIND) || (state_q == ST_TIMH) || (state_q == ST_TIMV);
        waddr_d   = wen_d ? xf_addr : waddr_q;
        wdata_d   = wen_d ? can_bit : wdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            fidx_q    <= 2'd0;
            dr_q      <= 3'd0;
            dc_q      <= 3'd0;
            tcnt_q    <= 3'd0;
            loc_y_q   <= 6'd0;
            loc_x_q   <= 6'd0;
            rot_q     <= 2'd0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            loc_err_q <= 1'b0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fidx_q    <= fidx_d;
            dr_q      <= dr_d;
            dc_q      <= dc_d;
            tcnt_q    <= tcnt_d;
            loc_y_q   <= loc_y_d;
            loc_x_q   <= loc_x_d;
            rot_q     <= rot_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            loc_err_q <= loc_err_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign loc_err    = loc_err_q;
    assign sram_wen   = wen_q;
    assign sram_waddr = waddr_q;
    assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_qr_pattern_writer.sv
// ---------------------------------------------------------------------------
// tb_qr_pattern_writer
//
// Bench for qr_pattern_writer. A reference model tracks, per job, the number
// of edges since start was accepted and derives every output from the
// documented timeline; the expected write stream is built from the pattern
// rules into exp_q. Writes seen on the SRAM port are also accumulated into an
// image that is diffed against a golden 21x21 pattern after each job.
// ---------------------------------------------------------------------------
module tb_qr_pattern_writer;

    localparam int AW  = 12;
    localparam int NW  = 157;
    localparam int SZ  = 21;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [5:0]    loc_y = 6'd0;
    logic [5:0]    loc_x = 6'd0;
    logic [1:0]    rotation_type = 2'd0;
    logic          busy;
    logic          done;
    logic          loc_err;
    logic          sram_wen;
    logic [AW-1:0] sram_waddr;
    logic          sram_wdata;

    always #5 clk = ~clk;

    qr_pattern_writer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .loc_y         (loc_y),
        .loc_x         (loc_x),
        .rotation_type (rotation_type),
        .busy          (busy),
        .done          (done),
        .loc_err       (loc_err),
        .sram_wen      (sram_wen),
        .sram_waddr    (sram_waddr),
        .sram_wdata    (sram_wdata)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;

    int  t = -1;          // edges since the accepting edge, -1 = no job yet
    bit  job_legal = 1'b1;
    bit  chk_en = 1'b0;
    logic [AW:0]   exp_q[$];   // {addr, data}
    logic [AW-1:0] last_addr = '0;
    logic          last_data = 1'b0;

    bit            img_val[4096];
    bit            img_wr[4096];
    logic [AW-1:0] log_addr[NW];
    logic          log_data[NW];
    int            wr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    // ---------------- pattern rules ----------------
    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Is canonical (r,c) a function-pattern module, and if so its value.
    function automatic void gold_rc(input int r, input int c, output bit hit, output bit val);
        int orr;
        int occ;
        int d;
        hit = 1'b0;
        val = 1'b0;
        for (int f = 0; f < 3; f++) begin
            orr = (f == 2) ? 14 : 0;
            occ = (f == 1) ? 14 : 0;
            if (r >= orr && r < orr + 7 && c >= occ && c < occ + 7) begin
                d = iabs(r - orr - 3);
                if (iabs(c - occ - 3) > d) d = iabs(c - occ - 3);
                hit = 1'b1;
                val = (d != 2);
            end
        end
        if (r == 6 && c >= 8 && c <= 12) begin
            hit = 1'b1;
            val = (c % 2 == 0);
        end
        if (c == 6 && r >= 8 && r <= 12) begin
            hit = 1'b1;
            val = (r % 2 == 0);
        end
    endfunction

    function automatic int phys(input int r, input int c, input int ly, input int lx, input int rot);
        int pr;
        int pc;
        case (rot)
            3:       begin pr = r;          pc = c;          end
            2:       begin pr = c;          pc = SZ - 1 - r; end
            1:       begin pr = SZ - 1 - c; pc = r;          end
            default: begin pr = SZ - 1 - r; pc = SZ - 1 - c; end
        endcase
        return (ly + pr) * 64 + (lx + pc);
    endfunction

    function automatic void push_write(input int r, input int c, input int ly, input int lx, input int rot);
        bit hit;
        bit val;
        gold_rc(r, c, hit, val);
        exp_q.push_back({AW'(phys(r, c, ly, lx, rot)), val});
    endfunction

    function automatic void build_exp(input int ly, input int lx, input int rot);
        exp_q.delete();
        for (int f = 0; f < 3; f++)
            for (int dr = 0; dr < 7; dr++)
                for (int dc = 0; dc < 7; dc++)
                    push_write(((f == 2) ? 14 : 0) + dr, ((f == 1) ? 14 : 0) + dc, ly, lx, rot);
        for (int i = 8; i <= 12; i++) push_write(6, i, ly, lx, rot);
        for (int i = 8; i <= 12; i++) push_write(i, 6, ly, lx, rot);
    endfunction

    function automatic bit model_idle();
        return (t < 0) || (job_legal && t >= NW + 1) || (!job_legal && t >= 1);
    endfunction

    // ---------------- model step + compare, every cycle ----------------
    task automatic compare_cycle();
        bit eb;
        bit ed;
        bit ee;
        bit ew;
        logic [AW:0] e;
        eb = 1'b0; ed = 1'b0; ee = 1'b0; ew = 1'b0;
        if (t >= 0) begin
            if (job_legal) begin
                eb = (t <= NW);
                ed = (t == NW + 1);
                ew = (t >= 1 && t <= NW);
            end else begin
                eb = (t == 0);
                ed = (t == 1);
                ee = (t == 1);
            end
        end
        if (ew) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL exp_q_empty: got write at t=%0d want none left", t);
            end else begin
                e = exp_q.pop_front();
                last_addr = e[AW:1];
                last_data = e[0];
            end
        end
        chk("busy", 32'(busy), 32'(eb));
        chk("done", 32'(done), 32'(ed));
        chk("loc_err", 32'(loc_err), 32'(ee));
        chk("wen", 32'(sram_wen), 32'(ew));
        chk("waddr", 32'(sram_waddr), 32'(last_addr));
        chk("wdata", 32'(sram_wdata), 32'(last_data));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                t = -1;
            end else if (model_idle() && start === 1'b1) begin
                t = 0;
                job_legal = (loc_y <= 6'd43) && (loc_x <= 6'd43);
                exp_q.delete();
                if (job_legal) build_exp(loc_y, loc_x, rotation_type);
                wr_cnt = 0;
            end else if (t >= 0 && t < 100000) begin
                t++;
            end
            #1;
            if (sram_wen === 1'b1) begin
                img_wr[sram_waddr] = 1'b1;
                img_val[sram_waddr] = sram_wdata;
                if (wr_cnt < NW) begin
                    log_addr[wr_cnt] = sram_waddr;
                    log_data[wr_cnt] = sram_wdata;
                end
                wr_cnt++;
            end
            if (chk_en) compare_cycle();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        t = -1;
        exp_q.delete();
        last_addr = '0;
        last_data = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_loc_err", 32'(loc_err), 32'd0);
        chk("rst_wen", 32'(sram_wen), 32'd0);
        chk("rst_waddr", 32'(sram_waddr), 32'd0);
        chk("rst_wdata", 32'(sram_wdata), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_t(input int target, input int budget);
        int n;
        n = 0;
        while (n < budget && t != target) begin
            @(posedge clk);
            #2;
            n++;
        end
        total++;
        if (t != target) begin
            bad++;
            $display("FAIL wait_t_timeout: got t=%0d want %0d", t, target);
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            #2;
            if (done === 1'b1) break;
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL done_timeout: got no done within %0d cycles want done", budget);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 4096; i++) begin
            img_wr[i] = 1'b0;
            img_val[i] = 1'b0;
        end
    endtask

    // Launch a job with a one-cycle start pulse; optionally re-pulse start at
    // edge poke while busy. Inputs are scrambled after launch to prove latching.
    task automatic launch(input int ly, input int lx, input int rot, input int poke);
        clear_img();
        @(negedge clk);
        loc_y = 6'(ly);
        loc_x = 6'(lx);
        rotation_type = 2'(rot);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        loc_y = 6'($urandom_range(0, 63));
        loc_x = 6'($urandom_range(0, 63));
        rotation_type = 2'($urandom_range(0, 3));
        if (poke > 0) begin
            wait_t(poke, 300);
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic check_image(input int ly, input int lx, input int rot);
        bit gw[4096];
        bit gv[4096];
        bit hit;
        bit val;
        int a;
        int diffs;
        for (int i = 0; i < 4096; i++) begin
            gw[i] = 1'b0;
            gv[i] = 1'b0;
        end
        for (int r = 0; r < SZ; r++)
            for (int c = 0; c < SZ; c++) begin
                gold_rc(r, c, hit, val);
                if (hit) begin
                    a = phys(r, c, ly, lx, rot);
                    gw[a] = 1'b1;
                    gv[a] = val;
                end
            end
        diffs = 0;
        for (int i = 0; i < 4096; i++)
            if (gw[i] != img_wr[i] || (gw[i] && gv[i] != img_val[i])) diffs++;
        chk("img_diff", 32'(diffs), 32'd0);
        chk("n_writes", 32'(wr_cnt), 32'(NW));
    endtask

    task automatic run_job(input int ly, input int lx, input int rot);
        launch(ly, lx, rot, 0);
        wait_done(400);
        if (ly <= 43 && lx <= 43) begin
            check_image(ly, lx, rot);
        end else begin
            chk("illegal_err", 32'(loc_err), 32'd1);
            chk("illegal_edge", 32'(t), 32'd1);
            chk("illegal_writes", 32'(wr_cnt), 32'd0);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int ly;
        int lx;
        int rot;
        int orient_addr[4];
        orient_addr[0] = 1960;
        orient_addr[1] = 1940;
        orient_addr[2] = 680;
        orient_addr[3] = 660;

        // Reset asserted mid-cycle, then idle with no start
        #12;
        do_reset();
        chk_en = 1'b1;
        repeat (5) @(negedge clk);

        // Canonical orientation at the origin, with hand-computed pins
        launch(0, 0, 3, 0);
        wait_done(400);
        chk("done_edge", 32'(t), 32'd158);
        check_image(0, 0, 3);
        chk("w0_addr", 32'(log_addr[0]), 32'd0);
        chk("w0_data", 32'(log_data[0]), 32'd1);
        chk("w8_addr", 32'(log_addr[8]), 32'd65);
        chk("w8_data", 32'(log_data[8]), 32'd0);
        chk("w16_addr", 32'(log_addr[16]), 32'd130);
        chk("w16_data", 32'(log_data[16]), 32'd1);
        chk("w147_addr", 32'(log_addr[147]), 32'd392);
        chk("w147_data", 32'(log_data[147]), 32'd1);
        chk("w148_addr", 32'(log_addr[148]), 32'd393);
        chk("w148_data", 32'(log_data[148]), 32'd0);
        chk("w152_addr", 32'(log_addr[152]), 32'd518);
        chk("w152_data", 32'(log_data[152]), 32'd1);

        // All four orientations at (10,20)
        for (int r = 0; r < 4; r++) begin
            run_job(10, 20, r);
            chk($sformatf("orient%0d_w0", r), 32'(log_addr[0]), 32'(orient_addr[r]));
        end

        // Illegal locations
        run_job(44, 0, 3);
        run_job(0, 63, 1);

        // Extra start while busy is ignored
        launch(5, 7, 2, 40);
        wait_done(400);
        check_image(5, 7, 2);

        // Start held high across done relaunches on the following IDLE cycle
        clear_img();
        @(negedge clk);
        loc_y = 6'd43;
        loc_x = 6'd43;
        rotation_type = 2'd0;
        start = 1'b1;
        wait_done(400);
        @(posedge clk);
        #2;
        chk("relaunch_busy", 32'(busy), 32'd1);
        chk("relaunch_t", 32'(t), 32'd0);
        @(negedge clk);
        start = 1'b0;
        wait_done(400);
        check_image(43, 43, 0);

        // Reset during write 50, then a full job
        launch(12, 3, 1, 0);
        wait_t(51, 300);
        chk("pre_rst_wen", 32'(sram_wen), 32'd1);
        #2;
        do_reset();
        launch(12, 3, 1, 0);
        wait_done(400);
        check_image(12, 3, 1);
        chk("post_rst_w0", 32'(log_addr[0]), 32'(phys(0, 0, 12, 3, 1)));

        // Randomised jobs, some with out-of-range locations
        for (int j = 0; j < 12; j++) begin
            ly = $urandom_range(0, 43);
            lx = $urandom_range(0, 43);
            rot = $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) ly = $urandom_range(44, 63);
            if ($urandom_range(0, 4) == 0) lx = $urandom_range(44, 63);
            run_job(ly, lx, rot);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test want finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
